mbist_march_engine: RTL and testbench

MBIST_MARCH_ENGINE -- requirements
Module: mbist_march_engine

---
 rtl/mbist_march_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_mbist_march_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_engine.sv
// March-test MBIST engine: drives NCH memory channels in lock-step with MATS+ or March C-,
// compares read data through an RD_LAT-deep tag pipeline and keeps sticky per-channel
// fail flags.
// Optional first-fail logging (FAIL_ADDR / FAIL_CH capture) is built only when
// MBIST_FAIL_LOG_EN is defined; otherwise those outputs are tied to zero.
module mbist_march_engine #(
    parameter int unsigned AW     = 9,
    parameter int unsigned DW     = 36,
    parameter int unsigned NCH    = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                                       TCLK,
    input  logic                                       RESET_L,
    input  logic                                       TEST_H,
    input  logic [1:0]                                 ALG_SEL,
    output logic [NCH-1:0]                             MEM_EN,
    output logic                                       MEM_WE,
    output logic [AW-1:0]                              MEM_ADDR,
    output logic [DW-1:0]                              MEM_DI,
    input  logic [NCH*DW-1:0]                          MEM_DO,
    output logic                                       BUSY,
    output logic                                       DONE,
    output logic                                       FAIL,
    output logic [NCH-1:0]                             FAIL_VEC,
    output logic [AW-1:0]                              FAIL_ADDR,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]   FAIL_CH
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StEnd} state_e;

    state_e          state_q, state_d;
    logic            alg_q, alg_d;       // 0: MATS+, 1: March C-
    logic [2:0]      elem_q, elem_d;
    logic            op_q, op_d;         // operation index inside a two-op element
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      drain_q, drain_d;
    logic            start, abort;

    logic            el_down, el_two, el_last, el_val, el_single_rd;
    logic            next_down, op_rd, op_val, op_last_in_elem, sweep_end, issue;

    logic [RD_LAT-1:0] pv_q;             // read-valid tags
    logic [RD_LAT-1:0] pe_q;             // expected background bit per read
    logic [NCH-1:0]    mismatch;
    logic [NCH-1:0]    fail_vec_q;

    // Decode the current march element: direction, op count, background and last flag.
    // Two-op elements are always (r v, w ~v); single-op elements are w0 or r0.
    always_comb begin
        el_down      = 1'b0;
        el_two       = 1'b1;
        el_last      = 1'b0;
        el_val       = 1'b0;
        el_single_rd = 1'b0;
        if (!alg_q) begin
            case (elem_q)
                3'd0:    el_two = 1'b0;
                3'd1:    el_val = 1'b0;
                default: begin el_down = 1'b1; el_val = 1'b1; el_last = 1'b1; end
            endcase
        end else begin
            case (elem_q)
                3'd0:    el_two = 1'b0;
                3'd1:    el_val = 1'b0;
                3'd2:    el_val = 1'b1;
                3'd3:    el_down = 1'b1;
                3'd4:    begin el_down = 1'b1; el_val = 1'b1; end
                default: begin el_two = 1'b0; el_single_rd = 1'b1; el_last = 1'b1; end
            endcase
        end
    end

    assign next_down       = alg_q ? (elem_q == 3'd2 || elem_q == 3'd3) : (elem_q == 3'd1);
    assign op_rd           = el_two ? ~op_q : el_single_rd;
    assign op_val          = el_two ? (op_q ? ~el_val : el_val) : el_val;
    assign op_last_in_elem = ~el_two | op_q;
    assign sweep_end       = el_down ? (addr_q == '0) : (addr_q == '1);
    assign issue           = (state_q == StRun);

    // Next-state logic: FSM plus element/address/op sequencing.
    always_comb begin
        state_d = state_q;
        alg_d   = alg_q;
        elem_d  = elem_q;
        op_d    = op_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        start   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (TEST_H) begin
                    state_d = StRun;
                    start   = 1'b1;
                    alg_d   = (ALG_SEL != 2'b00);
                    elem_d  = 3'd0;
                    op_d    = 1'b0;
                    addr_d  = '0;
                end
            end
            StRun: begin
                if (!TEST_H) begin
                    state_d = StIdle;
                    abort   = 1'b1;
                end else if (op_last_in_elem) begin
                    op_d = 1'b0;
                    if (sweep_end) begin
                        if (el_last) begin
                            state_d = StDrain;
                            drain_d = 3'd0;
                        end else begin
                            // Next element starts in the following cycle, no bubble.
                            elem_d = elem_q + 3'd1;
                            addr_d = next_down ? '1 : '0;
                        end
                    end else begin
                        addr_d = el_down ? addr_q - 1'b1 : addr_q + 1'b1;
                    end
                end else begin
                    op_d = 1'b1;
                end
            end
            StDrain: begin
                if (!TEST_H) begin
                    state_d = StIdle;
                    abort   = 1'b1;
                end else if (drain_q == 3'(RD_LAT)) begin
                    state_d = StEnd;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            StEnd: begin
                if (!TEST_H) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge TCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= StIdle;
            alg_q   <= 1'b0;
            elem_q  <= 3'd0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            drain_q <= 3'd0;
        end else begin
            state_q <= state_d;
            alg_q   <= alg_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    assign MEM_EN   = {NCH{issue}};
    assign MEM_WE   = issue & ~op_rd;
    assign MEM_ADDR = issue ? addr_q : '0;
    assign MEM_DI   = {DW{issue & op_val}};
    assign BUSY     = (state_q == StRun) || (state_q == StDrain);
    assign DONE     = (state_q == StEnd);

    // Read tag pipeline; an abort empties it so stale reads are never compared.
    always_ff @(posedge TCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            pv_q <= '0;
            pe_q <= '0;
        end else begin
            pe_q[0] <= op_val;
            for (int unsigned i = 1; i < RD_LAT; i++) pe_q[i] <= pe_q[i-1];
            if (abort) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= issue & op_rd;
                for (int unsigned i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
            end
        end
    end

    // Per-channel compare against the delayed all-zero / all-one background.
    always_comb begin
        mismatch = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            mismatch[k] = pv_q[RD_LAT-1] && (MEM_DO[k*DW +: DW] != {DW{pe_q[RD_LAT-1]}});
        end
    end

    // Sticky fail flags, cleared only when a new test starts.
    always_ff @(posedge TCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            fail_vec_q <= '0;
        end else if (start) begin
            fail_vec_q <= '0;
        end else begin
            fail_vec_q <= fail_vec_q | mismatch;
        end
    end

    assign FAIL_VEC = fail_vec_q;
    assign FAIL     = |fail_vec_q;

`ifdef MBIST_FAIL_LOG_EN
    logic [AW-1:0]  pa_q [RD_LAT];
    logic [CHW-1:0] low_ch;
    logic [AW-1:0]  fail_addr_q;
    logic [CHW-1:0] fail_ch_q;

    // Address tag travels alongside the read-valid tag.
    always_ff @(posedge TCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            for (int unsigned i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
        end else begin
            pa_q[0] <= addr_q;
            for (int unsigned i = 1; i < RD_LAT; i++) pa_q[i] <= pa_q[i-1];
        end
    end

    // Lowest-numbered failing channel in this cycle.
    always_comb begin
        low_ch = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mismatch[k]) low_ch = CHW'(k);
        end
    end

    // Capture only the first mismatch of a test; frozen once any flag is set.
    always_ff @(posedge TCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            fail_addr_q <= '0;
            fail_ch_q   <= '0;
        end else if (start) begin
            fail_addr_q <= '0;
            fail_ch_q   <= '0;
        end else if ((fail_vec_q == '0) && (|mismatch)) begin
            fail_addr_q <= pa_q[RD_LAT-1];
            fail_ch_q   <= low_ch;
        end
    end

    assign FAIL_ADDR = fail_addr_q;
    assign FAIL_CH   = fail_ch_q;
`else
    assign FAIL_ADDR = '0;
    assign FAIL_CH   = '0;
`endif

endmodule

// File: tb/tb_mbist_march_engine.sv
// Directed bench for mbist_march_engine: two engines (RD_LAT=1 and RD_LAT=3) with
// behavioural memories and injectable stuck-at-1 read faults.
module tb_mbist_march_engine;

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned NCH = 2;
`ifdef MBIST_FAIL_LOG_EN
    localparam bit LogEn = 1'b1;
`else
    localparam bit LogEn = 1'b0;
`endif

    logic              TCLK;
    logic              RESET_L;
    logic              TEST_H, TEST_H3;
    logic [1:0]        ALG_SEL, ALG_SEL3;
    logic [NCH-1:0]    MEM_EN, MEM_EN3;
    logic              MEM_WE, MEM_WE3;
    logic [AW-1:0]     MEM_ADDR, MEM_ADDR3;
    logic [DW-1:0]     MEM_DI, MEM_DI3;
    logic [NCH*DW-1:0] rd1, rd3a, rd3b, rd3c;
    logic              BUSY, BUSY3, DONE, DONE3, FAIL, FAIL3;
    logic [NCH-1:0]    FAIL_VEC, FAIL_VEC3;
    logic [AW-1:0]     FAIL_ADDR, FAIL_ADDR3;
    logic [0:0]        FAIL_CH, FAIL_CH3;

    logic              f1_en, f3_en;
    logic [DW-1:0]     mem1 [NCH][16];
    logic [DW-1:0]     mem3 [NCH][16];

    int n_checks = 0;
    int n_fail   = 0;
    int r_run, r_drain, r_operr, r_failcyc, r_startlat;
    bit r_done;
    logic [5:0] exp_ops [$];  // {we, data bit, addr}

    mbist_march_engine #(.AW(AW), .DW(DW), .NCH(NCH), .RD_LAT(1)) dut (
        .TCLK(TCLK), .RESET_L(RESET_L), .TEST_H(TEST_H), .ALG_SEL(ALG_SEL),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DI(MEM_DI),
        .MEM_DO(rd1), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_VEC(FAIL_VEC),
        .FAIL_ADDR(FAIL_ADDR), .FAIL_CH(FAIL_CH)
    );

    mbist_march_engine #(.AW(AW), .DW(DW), .NCH(NCH), .RD_LAT(3)) dut3 (
        .TCLK(TCLK), .RESET_L(RESET_L), .TEST_H(TEST_H3), .ALG_SEL(ALG_SEL3),
        .MEM_EN(MEM_EN3), .MEM_WE(MEM_WE3), .MEM_ADDR(MEM_ADDR3), .MEM_DI(MEM_DI3),
        .MEM_DO(rd3c), .BUSY(BUSY3), .DONE(DONE3), .FAIL(FAIL3), .FAIL_VEC(FAIL_VEC3),
        .FAIL_ADDR(FAIL_ADDR3), .FAIL_CH(FAIL_CH3)
    );

    initial TCLK = 1'b0;
    always #5 TCLK = ~TCLK;

    // Read port with a stuck-at-1 on channel 1 bit 3 at address 5.
    function automatic logic [NCH*DW-1:0] fetch1(input logic [AW-1:0] a);
        logic [NCH*DW-1:0] w;
        for (int c = 0; c < NCH; c++) w[c*DW +: DW] = mem1[c][a];
        if (f1_en && a == 4'd5) w[DW + 3] = 1'b1;
        return w;
    endfunction

    // Read port with a stuck-at-1 on bit 0 of both channels at address 9.
    function automatic logic [NCH*DW-1:0] fetch3(input logic [AW-1:0] a);
        logic [NCH*DW-1:0] w;
        for (int c = 0; c < NCH; c++) w[c*DW +: DW] = mem3[c][a];
        if (f3_en && a == 4'd9) begin
            w[0]  = 1'b1;
            w[DW] = 1'b1;
        end
        return w;
    endfunction

    always @(posedge TCLK) begin
        for (int c = 0; c < NCH; c++) if (MEM_EN[c] && MEM_WE) mem1[c][MEM_ADDR] <= MEM_DI;
        if (MEM_EN != 0 && !MEM_WE) rd1 <= fetch1(MEM_ADDR);
    end

    always @(posedge TCLK) begin
        for (int c = 0; c < NCH; c++) if (MEM_EN3[c] && MEM_WE3) mem3[c][MEM_ADDR3] <= MEM_DI3;
        if (MEM_EN3 != 0 && !MEM_WE3) rd3a <= fetch3(MEM_ADDR3);
        rd3b <= rd3a;
        rd3c <= rd3b;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic add_elem(input bit down, input bit two, input bit rd0, input bit d0);
        logic [3:0] a;
        for (int i = 0; i < 16; i++) begin
            a = down ? 4'(15 - i) : 4'(i);
            exp_ops.push_back({~rd0, d0, a});
            if (two) exp_ops.push_back({1'b1, ~d0, a});
        end
    endtask

    task automatic gen(input logic [1:0] alg);
        exp_ops.delete();
        add_elem(1'b0, 1'b0, 1'b0, 1'b0);             // up(w0)
        add_elem(1'b0, 1'b1, 1'b1, 1'b0);             // up(r0,w1)
        if (alg == 2'b00) begin
            add_elem(1'b1, 1'b1, 1'b1, 1'b1);         // down(r1,w0)
        end else begin
            add_elem(1'b0, 1'b1, 1'b1, 1'b1);         // up(r1,w0)
            add_elem(1'b1, 1'b1, 1'b1, 1'b0);         // down(r0,w1)
            add_elem(1'b1, 1'b1, 1'b1, 1'b1);         // down(r1,w0)
            add_elem(1'b0, 1'b0, 1'b1, 1'b0);         // up(r0)
        end
    endtask

    // Raise TEST_H and follow one run on the RD_LAT=1 engine; abort_at >= 0 drops TEST_H
    // after that RUN cycle. ALG_SEL is flipped mid-run and must be ignored.
    task automatic run_test(input logic [1:0] alg, input int abort_at);
        int  cyc;
        bit  started;
        logic [5:0] e;
        gen(alg);
        r_run = 0; r_drain = 0; r_operr = 0; r_failcyc = -1; r_startlat = -1; r_done = 0;
        cyc = 0; started = 0;
        ALG_SEL = alg;
        TEST_H  = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge TCLK);
            if (DONE) begin r_done = 1; break; end
            if (!started) begin
                if (MEM_EN == 0) continue;
                started = 1;
                r_startlat = t + 1;
            end
            if (MEM_EN == 2'b11) begin
                if (r_run < exp_ops.size()) begin
                    e = exp_ops[r_run];
                    if (MEM_WE != e[5] || MEM_ADDR != e[3:0] ||
                        (MEM_WE && MEM_DI != {DW{e[4]}})) r_operr++;
                end else begin
                    r_operr++;
                end
                r_run++;
            end else if (BUSY) begin
                r_drain++;
            end else begin
                break;
            end
            if (FAIL && r_failcyc < 0) r_failcyc = cyc;
            if (cyc == 10) ALG_SEL = ALG_SEL ^ 2'b01;
            if (cyc == abort_at) TEST_H = 1'b0;
            cyc++;
        end
    endtask

    task automatic end_run(input string tag);
        TEST_H = 1'b0;
        @(negedge TCLK);
        check_eq(tag, DONE, 1'b0);
    endtask

    initial begin
        int n3_run, n3_drain;
        bit done3;
        RESET_L = 1'b0; TEST_H = 1'b0; TEST_H3 = 1'b0;
        ALG_SEL = 2'b00; ALG_SEL3 = 2'b00; f1_en = 1'b0; f3_en = 1'b0;
        #1;
        check_eq("rst_mem_en", MEM_EN, 2'b00);
        check_eq("rst_mem_we_addr_di", {MEM_WE, MEM_ADDR, MEM_DI}, 0);
        check_eq("rst_busy_done_fail", {BUSY, DONE, FAIL}, 3'b000);
        check_eq("rst_fail_vec", FAIL_VEC, 2'b00);
        check_eq("rst_fail_log", {FAIL_ADDR, FAIL_CH}, 0);
        repeat (3) @(negedge TCLK);
        RESET_L = 1'b1;
        @(negedge TCLK);
        check_eq("idle_busy", BUSY, 1'b0);

        // MATS+, fault-free
        run_test(2'b00, -1);
        check_eq("mats_done", r_done, 1'b1);
        check_eq("mats_start_lat", r_startlat, 1);
        check_eq("mats_run_cycles", r_run, 80);
        check_eq("mats_drain_cycles", r_drain, 2);
        check_eq("mats_op_seq_errs", r_operr, 0);
        check_eq("mats_fail", FAIL, 1'b0);
        check_eq("mats_busy_in_end", BUSY, 1'b0);
        end_run("mats_done_clear");

        // March C-, fault-free
        run_test(2'b01, -1);
        check_eq("mc_done", r_done, 1'b1);
        check_eq("mc_run_cycles", r_run, 160);
        check_eq("mc_drain_cycles", r_drain, 2);
        check_eq("mc_op_seq_errs", r_operr, 0);
        check_eq("mc_fail", FAIL, 1'b0);
        end_run("mc_done_clear");

        // March C-, channel 1 bit 3 stuck-at-1 at address 5
        f1_en = 1'b1;
        run_test(2'b01, -1);
        check_eq("sa1_done", r_done, 1'b1);
        check_eq("sa1_run_cycles", r_run, 160);
        check_eq("sa1_fail_vec", FAIL_VEC, 2'b10);
        check_eq("sa1_fail", FAIL, 1'b1);
        check_eq("sa1_fail_cycle", r_failcyc, 28);
        check_eq("sa1_fail_addr", FAIL_ADDR, LogEn ? 4'd5 : 4'd0);
        check_eq("sa1_fail_ch", FAIL_CH, LogEn ? 1'b1 : 1'b0);
        end_run("sa1_done_clear");

        // Abort after RUN cycle 40, fault still present: flags must survive
        run_test(2'b01, 40);
        check_eq("abort_run_cycles", r_run, 41);
        check_eq("abort_no_done", r_done, 1'b0);
        check_eq("abort_outputs", {MEM_EN, BUSY, DONE}, 4'b0000);
        check_eq("abort_fail_vec_kept", FAIL_VEC, 2'b10);
        check_eq("abort_fail_addr_kept", FAIL_ADDR, LogEn ? 4'd5 : 4'd0);
        @(negedge TCLK);
        check_eq("abort_idle_done", {BUSY, DONE}, 2'b00);

        // Fresh run after abort, fault removed: flags cleared at start
        f1_en = 1'b0;
        run_test(2'b01, -1);
        check_eq("rerun_done", r_done, 1'b1);
        check_eq("rerun_run_cycles", r_run, 160);
        check_eq("rerun_op_seq_errs", r_operr, 0);
        check_eq("rerun_fail_vec", FAIL_VEC, 2'b00);
        end_run("rerun_done_clear");

        // RD_LAT=3, both channels fail at address 9 in the same cycle; reserved ALG_SEL
        f3_en = 1'b1; n3_run = 0; n3_drain = 0; done3 = 0;
        ALG_SEL3 = 2'b11; TEST_H3 = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge TCLK);
            if (DONE3) begin done3 = 1; break; end
            if (MEM_EN3 == 2'b11) n3_run++;
            else if (BUSY3) n3_drain++;
        end
        check_eq("lat3_done", done3, 1'b1);
        check_eq("lat3_run_cycles", n3_run, 160);
        check_eq("lat3_drain_cycles", n3_drain, 4);
        check_eq("lat3_fail_vec", FAIL_VEC3, 2'b11);
        check_eq("lat3_fail_ch", FAIL_CH3, 1'b0);
        check_eq("lat3_fail_addr", FAIL_ADDR3, LogEn ? 4'd9 : 4'd0);
        TEST_H3 = 1'b0;
        @(negedge TCLK);

        // Asynchronous reset in the middle of a failing run
        f1_en = 1'b1; ALG_SEL = 2'b01; TEST_H = 1'b1;
        repeat (37) @(negedge TCLK);
        check_eq("prerst_busy_fail", {BUSY, FAIL}, 2'b11);
        #1 RESET_L = 1'b0;
        #1;
        check_eq("arst_mem_en", MEM_EN, 2'b00);
        check_eq("arst_mem_we_addr_di", {MEM_WE, MEM_ADDR, MEM_DI}, 0);
        check_eq("arst_busy_done_fail", {BUSY, DONE, FAIL}, 3'b000);
        check_eq("arst_fail_vec", FAIL_VEC, 2'b00);
        check_eq("arst_fail_log", {FAIL_ADDR, FAIL_CH}, 0);
        repeat (2) @(negedge TCLK);

        // Release with TEST_H already high: run starts on the first edge
        f1_en = 1'b0;
        RESET_L = 1'b1;
        run_test(2'b01, -1);
        check_eq("rel_start_lat", r_startlat, 1);
        check_eq("rel_run_cycles", r_run, 160);
        check_eq("rel_done", r_done, 1'b1);
        check_eq("rel_fail", FAIL, 1'b0);
        end_run("rel_done_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
